// File: rtl/receptor_ascii_quadro.sv
// ============================================================================
// Module : receptor_ascii_quadro
// Brief  : 7O1 serial receiver assembling the 8-character sonar frame
//          "CAE,CDU#" into angle and distance fields with error flags.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module receptor_ascii_quadro #(
  parameter int         CLKS_POR_BIT   = 434,
  parameter logic [6:0] TERM_ANGULO    = 7'h2C,
  parameter logic [6:0] TERM_DISTANCIA = 7'h23
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [6:0] centena_angulo,
  output logic [6:0] dezena_angulo,
  output logic [6:0] unidade_angulo,
  output logic [6:0] caractere_final_angulo,
  output logic [6:0] centena_distancia,
  output logic [6:0] dezena_distancia,
  output logic [6:0] unidade_distancia,
  output logic [6:0] caractere_final_distancia,
  output logic       pronto,
  output logic       erro_paridade,
  output logic       erro_quadro,
  output logic [2:0] db_indice,
  output logic [3:0] db_estado
);

  localparam int              c_CW       = $clog2(CLKS_POR_BIT);
  localparam logic [c_CW-1:0] c_FIM_BIT  = c_CW'(CLKS_POR_BIT - 1);
  localparam logic [c_CW-1:0] c_FIM_MEIO = c_CW'(CLKS_POR_BIT / 2 - 1);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    ESPERA         = 4'd1,
    CONFIRMA_START = 4'd2,
    DADOS          = 4'd3,
    PARIDADE       = 4'd4,
    STOP           = 4'd5,
    AVALIA         = 4'd6,
    AGUARDA_IDLE   = 4'd7
  } estado_t;

  estado_t         r_estado;
  estado_t         w_proximo;
  logic [1:0]      r_sinc;
  logic            w_rx;
  logic [c_CW-1:0] r_cont;
  logic [2:0]      r_nbits;
  logic            w_amostra;
  logic [6:0]      r_dados;
  logic            r_paridade;
  logic            r_stop;
  logic [2:0]      r_indice;
  logic            w_paridade_ok;
  logic            w_eh_term;
  logic            w_slot_ok;
  logic [6:0]      r_trab  [0:7];
  logic [6:0]      r_saida [0:7];
  logic            r_pronto;
  logic            r_erro_paridade;
  logic            r_erro_quadro;

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_sinc <= 2'b11;
    else        r_sinc <= {r_sinc[0], entrada_serial};
  end

  assign w_rx = r_sinc[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= INICIAL;
    else        r_estado <= w_proximo;
  end

  always_comb begin
    w_amostra = 1'b0;
    case (r_estado)
      CONFIRMA_START:       w_amostra = (r_cont == c_FIM_MEIO);
      DADOS, PARIDADE, STOP: w_amostra = (r_cont == c_FIM_BIT);
      default:              w_amostra = 1'b0;
    endcase
  end

  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      INICIAL:        w_proximo = ESPERA;
      ESPERA:         if (!w_rx) w_proximo = CONFIRMA_START;
      CONFIRMA_START: if (w_amostra) w_proximo = w_rx ? ESPERA : DADOS;
      DADOS:          if (w_amostra && r_nbits == 3'd6) w_proximo = PARIDADE;
      PARIDADE:       if (w_amostra) w_proximo = STOP;
      STOP:           if (w_amostra) w_proximo = AVALIA;
      AVALIA:         w_proximo = r_stop ? ESPERA : AGUARDA_IDLE;
      AGUARDA_IDLE:   if (w_rx) w_proximo = ESPERA;
      default:        w_proximo = INICIAL;
    endcase
  end

  // Bit timer restarts at every sample so each sample lands mid-bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cont     <= '0;
      r_nbits    <= '0;
      r_dados    <= '0;
      r_paridade <= 1'b0;
      r_stop     <= 1'b1;
    end else begin
      if (r_estado == ESPERA || w_amostra) r_cont <= '0;
      else                                 r_cont <= r_cont + c_CW'(1);

      if (r_estado == CONFIRMA_START) r_nbits <= '0;
      else if (r_estado == DADOS && w_amostra) r_nbits <= r_nbits + 3'd1;

      if (w_amostra) begin
        case (r_estado)
          DADOS:    r_dados    <= {w_rx, r_dados[6:1]};
          PARIDADE: r_paridade <= w_rx;
          STOP:     r_stop     <= w_rx;
          default:  ;
        endcase
      end
    end
  end

  assign w_paridade_ok = ^{r_dados, r_paridade};
  assign w_eh_term     = (r_dados == TERM_ANGULO) || (r_dados == TERM_DISTANCIA);

  always_comb begin
    w_slot_ok = 1'b0;
    case (r_indice)
      3'd3:    w_slot_ok = (r_dados == TERM_ANGULO);
      3'd7:    w_slot_ok = (r_dados == TERM_DISTANCIA);
      default: w_slot_ok = !w_eh_term;
    endcase
  end

  // Any rejected character restarts the frame at slot 0 and leaves outputs alone
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_indice        <= '0;
      r_pronto        <= 1'b0;
      r_erro_paridade <= 1'b0;
      r_erro_quadro   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_trab[i]  <= '0;
        r_saida[i] <= '0;
      end
    end else begin
      r_pronto        <= 1'b0;
      r_erro_paridade <= 1'b0;
      r_erro_quadro   <= 1'b0;
      if (r_estado == AVALIA) begin
        if (!r_stop) begin
          r_erro_quadro <= 1'b1;
          r_indice      <= '0;
        end else if (!w_paridade_ok) begin
          r_erro_paridade <= 1'b1;
          r_indice        <= '0;
        end else if (!w_slot_ok) begin
          r_erro_quadro <= 1'b1;
          r_indice      <= '0;
        end else begin
          r_trab[r_indice] <= r_dados;
          if (r_indice == 3'd7) begin
            for (int i = 0; i < 7; i++) r_saida[i] <= r_trab[i];
            r_saida[7] <= r_dados;
            r_pronto   <= 1'b1;
            r_indice   <= '0;
          end else begin
            r_indice <= r_indice + 3'd1;
          end
        end
      end
    end
  end

  assign centena_angulo            = r_saida[0];
  assign dezena_angulo             = r_saida[1];
  assign unidade_angulo            = r_saida[2];
  assign caractere_final_angulo    = r_saida[3];
  assign centena_distancia         = r_saida[4];
  assign dezena_distancia          = r_saida[5];
  assign unidade_distancia         = r_saida[6];
  assign caractere_final_distancia = r_saida[7];
  assign pronto                    = r_pronto;
  assign erro_paridade             = r_erro_paridade;
  assign erro_quadro               = r_erro_quadro;
  assign db_indice                 = r_indice;
  assign db_estado                 = r_estado;

endmodule

`default_nettype wire

// File: doc/receptor_ascii_quadro.md
# receptor_ascii_quadro

Serial receiver for the sonar measurement frame. It deserializes 7O1 UART characters from a single input line and assembles eight consecutive characters into an angle field and a distance field. Each field is three ASCII digits plus a terminator, with the frame laid out as `CAE,CDU#`. The block sits at the far end of the serial link from the frame transmitter and presents the last valid frame, plus error flags, to the consuming logic.

## Interface
- `CLKS_POR_BIT`, default 434 — clock cycles per serial bit (50 MHz / 115200 baud); must be ≥ 4 and even.
- `TERM_ANGULO`, default 7'h2C — required character at slot 3 (`,`).
- `TERM_DISTANCIA`, default 7'h23 — required character at slot 7 (`#`).

Ports:
- `clock` in 1 — single system clock, rising edge.
- `reset` in 1 — asynchronous, active-low reset.
- `entrada_serial` in 1 — serial line, idle high.
- `centena_angulo`, `dezena_angulo`, `unidade_angulo`, `caractere_final_angulo` out 7 each — slots 0–3 of the last valid frame.
- `centena_distancia`, `dezena_distancia`, `unidade_distancia`, `caractere_final_distancia` out 7 each — slots 4–7 of the last valid frame.
- `pronto` out 1 — one-cycle pulse when a new valid frame is latched onto the outputs.
- `erro_paridade` out 1 — one-cycle pulse on a parity failure.
- `erro_quadro` out 1 — one-cycle pulse on a stop-bit or frame-structure failure.
- `db_indice` out 3 — current slot index 0–7.
- `db_estado` out 4 — receiver FSM state encoding.

## Operation
- **Synchronizer:** `entrada_serial` passes through a 2-flop synchronizer whose flops reset to 1. All logic uses the synchronized line.
- **Character format:** LSB first — start (0), d0..d6, odd parity (d0..d6 plus the parity bit has an odd number of 1s), stop (1).
- **Receiver FSM:**
  - `INICIAL` → `ESPERA` once, after reset.
  - `ESPERA` → `CONFIRMA_START` when the line is 0.
  - `CONFIRMA_START` waits `CLKS_POR_BIT/2` cycles, then resamples the line. If 1 (glitch), return to `ESPERA` with no flag. If 0, go to `DADOS`.
  - `DADOS` samples 7 bits, each `CLKS_POR_BIT` cycles after the previous sample (mid-bit), then goes to `PARIDADE`.
  - `PARIDADE` samples one bit, then goes to `STOP`.
  - `STOP` samples one bit, then goes to `AVALIA`.
  - `AVALIA` lasts one cycle and always exits to `ESPERA`, or to `AGUARDA_IDLE` when the stop bit was 0.
  - `AGUARDA_IDLE` → `ESPERA` when the line is 1.
- **Checks in `AVALIA`, in priority order:**
  1. Stop bit = 0 → pulse `erro_quadro`, discard the character, set index to 0.
  2. Parity wrong → pulse `erro_paridade`, discard the character, set index to 0.
  3. Slot check fails → pulse `erro_quadro`, discard, set index to 0. A slot check fails when:
     - slot 3 is not `TERM_ANGULO`;
     - slot 7 is not `TERM_DISTANCIA`;
     - `TERM_ANGULO` or `TERM_DISTANCIA` arrives in any of slots 0–2 or 4–6.
  4. Otherwise, write the character to working register [index]. If index < 7, increment it. If index = 7:
     - copy all 8 working registers to the output registers in the same edge;
     - pulse `pronto`;
     - set index to 0.
- Exception to check 3: `TERM_DISTANCIA` arriving at a slot other than 7 also pulses `erro_quadro` and sets index to 0. This resynchronizes the frame, so the next character is treated as slot 0.
- Digit content is not range-checked; any character other than a terminator is accepted in the digit slots.
- **Output behaviour:** outputs change only on a valid complete frame and hold the previous frame otherwise. A partial or erroneous frame never alters the outputs.
- **Reset:** `reset` = 0 at any time, including mid-character or mid-frame, forces the following immediately:
  - FSM to `INICIAL`, index = 0;
  - all working and output character registers = 7'h00;
  - `pronto`, `erro_paridade`, `erro_quadro` = 0;
  - `db_estado` = 0, `db_indice` = 0.

## Timing
- Let T0 be the clock edge where the synchronized line is first seen low in `ESPERA`.
- The start is confirmed at T0 + `CLKS_POR_BIT/2`.
- Data bit k is sampled at T0 + `CLKS_POR_BIT/2` + (k+1)·`CLKS_POR_BIT`, for k = 0..6.
- Parity is sampled at +8·`CLKS_POR_BIT`; stop is sampled at +9·`CLKS_POR_BIT`.
- `AVALIA`, and hence the flags, `pronto` and the output update, occur exactly one cycle after the stop sample.
- Pin-to-`T0` latency is 2 cycles, from the synchronizer.
- `ESPERA` accepts a new start in the cycle right after `AVALIA`, so back-to-back characters with a 1-bit stop are supported.
- Flags are registered and high for exactly one cycle. `pronto` and an error flag are never high in the same cycle.

## Test plan
- **Frame after reset:** after reset with `CLKS_POR_BIT`=8, send `090,125#`, back to back → `pronto` pulses once, one cycle after the `#` stop sample. Outputs read 30,39,30,2C,31,32,35,23; no error flags.
- **Parity error:** send `090,` then `1` with its parity bit inverted, then `25#` → `erro_paridade` pulses on the `1`. The `#` then pulses `erro_quadro` at slot 2 and resyncs. `pronto` stays low and outputs keep the previous frame. A following `180,200#` → `pronto`, outputs 31,38,30,2C,32,30,30,23.
- **Glitch and stop-bit error:** a low glitch of 3 cycles on the idle line → no flags, index stays 0, FSM back in `ESPERA`. A character with stop = 0 → `erro_quadro`, FSM enters `AGUARDA_IDLE` and stays there while the line is held low. Releasing the line → `ESPERA`.
- **Wrong terminator at slot 3:** send `0905` → `erro_quadro` on the 4th character; `db_indice` returns to 0.
- **Reset mid-frame:** pull `reset` low during the parity bit of slot 5 → all outputs 0 immediately and `db_estado` = 0. After release, a full `045,010#` is received correctly.
